// File: rtl/spi_master_p_pkg.sv
// rtl/spi_master_p_pkg.sv - shared FSM state and latched configuration types for spi_master_p
package spi_master_p_pkg;

  // Widest divider / chip-select index the latched configuration can hold
  localparam int CFG_DIV_W = 16;
  localparam int CFG_SEL_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_HOLD  = 2'd3
  } spi_state_t;

  typedef struct packed {
    logic                 cpol;
    logic                 cpha;
    logic                 lsb;
    logic                 cs_hold;
    logic [CFG_SEL_W-1:0] cs_sel;
    logic [CFG_DIV_W-1:0] div;
  } spi_cfg_t;

endpackage

// File: rtl/spi_master_p_sck_gen.sv
// rtl/spi_master_p_sck_gen.sv - half-period timer, SCK toggle and leading/trailing edge strobes
module spi_sck_gen
  import spi_master_p_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [DIV_W-1:0] load_div,
  input  logic             load_cpol,
  input  logic             run,
  input  logic             shift,
  input  logic [DIV_W-1:0] div,
  input  logic             cpol,
  output logic             tick,
  output logic             sck,
  output logic             lead,
  output logic             trail
);

  logic [DIV_W-1:0] cnt;
  logic             sck_edge;

  // A half-period ends when the down-counter reaches zero
  assign tick     = run && (cnt == '0);
  assign sck_edge = tick && shift;
  // Leading edge moves SCK away from its idle level, trailing edge returns it
  assign lead     = sck_edge && (sck == cpol);
  assign trail    = sck_edge && (sck != cpol);

  // Counter reload per half-period; SCK parks at CPOL on a new word and toggles only while shifting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      sck <= 1'b0;
    end else if (load) begin
      cnt <= load_div;
      sck <= load_cpol;
    end else if (run) begin
      cnt <= tick ? div : cnt - 1'b1;
      if (sck_edge) sck <= ~sck;
    end
  end

endmodule

// File: rtl/spi_master_p.sv
// rtl/spi_master_p.sv - parametrised SPI master: four modes, SCK divider, bit order, chip selects
module spi_master_p
  import spi_master_p_pkg::*;
#(
  parameter int DW    = 8,
  parameter int DIV_W = 8,
  parameter int NCS   = 2,
  localparam int CSW  = (NCS > 1) ? $clog2(NCS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_cpol,
  input  logic             cfg_cpha,
  input  logic             cfg_lsb,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [CSW-1:0]   cfg_cs_sel,
  input  logic             cfg_cs_hold,
  input  logic             dma_req,
  input  logic [DW-1:0]    dma_din,
  input  logic             cpu_req,
  input  logic [DW-1:0]    cpu_din,
  output logic             start,
  output logic             busy,
  output logic             done,
  output logic [DW-1:0]    dout,
  output logic             sck,
  output logic             sdo,
  input  logic             sdi,
  output logic [NCS-1:0]   cs_n
);

  localparam int            EW        = ($clog2(2 * DW) < 5) ? 5 : $clog2(2 * DW);
  localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DW - 1);

  spi_state_t    state_q, state_d;
  spi_cfg_t      cfg_q, cfg_d;
  logic [DW-1:0] din, tx_sr, rx_sr;
  logic [EW-1:0] ecnt;
  logic          tick, lead, trail;
  logic          last_edge, sample_now, drive_now;
  logic          cfg_unused;

  assign busy       = (state_q != ST_IDLE);
  assign start      = (dma_req | cpu_req) & ~busy;
  assign din        = dma_req ? dma_din : cpu_din;
  assign last_edge  = (ecnt == LAST_EDGE);
  assign sample_now = cfg_q.cpha ? trail : lead;
  // First bit is already on sdo from SETUP, and the final edge must not launch a new bit
  assign drive_now  = (cfg_q.cpha ? lead : trail) && (ecnt != '0) && !last_edge;
  // Latched select and upper divider bits are kept for visibility only
  assign cfg_unused = ^{cfg_q.cs_sel, cfg_q.div};

  spi_sck_gen #(
    .DIV_W(DIV_W)
  ) u_sck_gen (
    .clk      (clk),
    .rst      (rst),
    .load     (start),
    .load_div (cfg_div),
    .load_cpol(cfg_cpol),
    .run      (busy),
    .shift    (state_q == ST_SHIFT),
    .div      (cfg_q.div[DIV_W-1:0]),
    .cpol     (cfg_q.cpol),
    .tick     (tick),
    .sck      (sck),
    .lead     (lead),
    .trail    (trail)
  );

  // Snapshot of the configuration taken when a word is accepted
  always_comb begin
    cfg_d         = '0;
    cfg_d.cpol    = cfg_cpol;
    cfg_d.cpha    = cfg_cpha;
    cfg_d.lsb     = cfg_lsb;
    cfg_d.cs_hold = cfg_cs_hold;
    cfg_d.cs_sel  = CFG_SEL_W'(cfg_cs_sel);
    cfg_d.div     = CFG_DIV_W'(cfg_div);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state: every non-idle step lasts whole half-periods
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_SETUP;
      ST_SETUP: if (tick) state_d = ST_SHIFT;
      ST_SHIFT: if (tick && last_edge) state_d = ST_HOLD;
      ST_HOLD:  if (tick) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Shift registers, edge counter, chip selects and completion strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_q <= '0;
      tx_sr <= '0;
      rx_sr <= '0;
      dout  <= '0;
      ecnt  <= '0;
      sdo   <= 1'b1;
      cs_n  <= '1;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        cfg_q <= cfg_d;
        ecnt  <= '0;
        sdo   <= cfg_lsb ? din[0] : din[DW-1];
        tx_sr <= cfg_lsb ? (din >> 1) : (din << 1);
        // Selecting a different line releases the old one in the same cycle
        cs_n  <= ~(NCS'(1) << cfg_cs_sel);
      end else if (state_q == ST_SHIFT && tick) begin
        ecnt <= ecnt + 1'b1;
        if (sample_now)
          rx_sr <= cfg_q.lsb ? {sdi, rx_sr[DW-1:1]} : {rx_sr[DW-2:0], sdi};
        if (drive_now) begin
          sdo   <= cfg_q.lsb ? tx_sr[0] : tx_sr[DW-1];
          tx_sr <= cfg_q.lsb ? (tx_sr >> 1) : (tx_sr << 1);
        end
      end else if (state_q == ST_HOLD && tick) begin
        dout <= rx_sr;
        done <= 1'b1;
        if (!cfg_q.cs_hold) cs_n <= '1;
      end
    end
  end

endmodule

// File: tb/tb_spi_master_p.sv
// tb/tb_spi_master_p.sv - self-checking bench for spi_master_p with a behavioural SPI slave
module tb_spi_master_p;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_cpol, cfg_cpha, cfg_lsb, cfg_cs_hold;
  logic [7:0] cfg_div;
  logic [0:0] cfg_cs_sel;
  logic       dma_req, cpu_req;
  logic [7:0] dma_din, cpu_din;
  logic       start, busy, done;
  logic [7:0] dout;
  logic       sck, sdo, sdi;
  logic [1:0] cs_n;

  logic       loop_en;
  logic       slv_sdi;
  logic       cs_watch;
  int         cs_viol;
  logic       first_sdo;
  logic [1:0] first_cs;
  int         tests  = 0;
  int         failed = 0;

  assign sdi = loop_en ? sdo : slv_sdi;

  spi_master_p #(
    .DW(8), .DIV_W(8), .NCS(2)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_cpol(cfg_cpol), .cfg_cpha(cfg_cpha), .cfg_lsb(cfg_lsb), .cfg_div(cfg_div),
    .cfg_cs_sel(cfg_cs_sel), .cfg_cs_hold(cfg_cs_hold),
    .dma_req(dma_req), .dma_din(dma_din), .cpu_req(cpu_req), .cpu_din(cpu_din),
    .start(start), .busy(busy), .done(done), .dout(dout),
    .sck(sck), .sdo(sdo), .sdi(sdi), .cs_n(cs_n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One word: the slave reacts to SCK edges seen at negedges, serving sword bit by bit
  // and capturing MOSI on its sample edges; expectations come from the mode rules.
  task automatic run_word(input logic cpol, input logic cpha, input logic lsb,
                          input logic [7:0] div, input logic sel, input logic hold,
                          input logic [7:0] din, input logic [7:0] sword, input logic slv_lsb,
                          input logic both_req, input logic poke_cpu);
    logic [7:0] exp_dout, mosi;
    logic       sck_prev, is_lead, sbit;
    int         k, leads, bi, mi, n_exp;
    n_exp = (2 * 8 + 2) * (int'(div) + 1);
    @(negedge clk);
    cfg_cpol = cpol; cfg_cpha = cpha; cfg_lsb = lsb; cfg_div = div;
    cfg_cs_sel = sel; cfg_cs_hold = hold;
    if (both_req) begin
      dma_req = 1'b1; cpu_req = 1'b1; dma_din = din; cpu_din = ~din;
    end else begin
      dma_req = 1'b0; cpu_req = 1'b1; cpu_din = din; dma_din = ~din;
    end
    bi = 0; mi = 0; leads = 0; mosi = '0;
    slv_sdi = slv_lsb ? sword[0] : sword[7];
    #1 chk("start_strobe", start, 1);
    sck_prev = cpol;
    @(negedge clk);
    dma_req = 1'b0; cpu_req = 1'b0;
    // Later cfg changes must not affect the word in flight
    cfg_cpol = 1'($urandom); cfg_cpha = 1'($urandom); cfg_lsb = 1'($urandom);
    cfg_div = 8'($urandom); cfg_cs_hold = 1'($urandom); cfg_cs_sel = 1'($urandom);
    k = 1;
    while (done !== 1'b1 && k < 4000) begin
      if (k == 1) begin
        first_sdo = sdo;
        first_cs  = cs_n;
      end
      if (sck !== sck_prev) begin
        is_lead = (sck != cpol);
        if (is_lead) leads++;
        if (is_lead ^ cpha) begin
          if (mi < 8) begin
            if (lsb) mosi[mi] = sdo; else mosi[7-mi] = sdo;
          end
          mi++;
        end else if (!(is_lead && leads == 1)) begin
          bi++;
          if (bi < 8) slv_sdi = slv_lsb ? sword[bi] : sword[7-bi];
        end
        sck_prev = sck;
      end
      if (cs_watch && cs_n !== 2'b01) cs_viol++;
      if (poke_cpu && k == 3) begin
        cpu_req = 1'b1;
        #1 chk("busy_req_dropped", start, 0);
      end
      if (k == 4) cpu_req = 1'b0;
      @(negedge clk);
      k++;
    end
    for (int i = 0; i < 8; i++) begin
      sbit = slv_lsb ? sword[i] : sword[7-i];
      if (lsb) exp_dout[i] = sbit; else exp_dout[7-i] = sbit;
    end
    if (loop_en) exp_dout = din;
    chk("done_seen", done, 1);
    // done rises (2*DW+2)*(div+1) clocks after the edge that accepted the word
    chk("done_latency", k, n_exp + 1);
    chk("dout", dout, exp_dout);
    chk("mosi_word", mosi, din);
    chk("sck_lead_edges", leads, 8);
    chk("sck_idle", sck, cpol);
    chk("busy_low_at_done", busy, 0);
  endtask

  initial begin
    int ndone;
    rst = 1'b1;
    cfg_cpol = 0; cfg_cpha = 0; cfg_lsb = 0; cfg_div = 0; cfg_cs_sel = 0; cfg_cs_hold = 0;
    dma_req = 0; cpu_req = 0; dma_din = 0; cpu_din = 0;
    loop_en = 0; slv_sdi = 0; cs_watch = 0; cs_viol = 0; first_sdo = 0; first_cs = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_start", start, 0);
    chk("rst_done", done, 0);
    chk("rst_dout", dout, 0);
    chk("rst_sck", sck, 0);
    chk("rst_sdo", sdo, 1);
    chk("rst_cs_n", cs_n, 2'b11);
    rst = 1'b0;

    // Mode 0 loopback
    loop_en = 1'b1;
    run_word(0, 0, 0, 8'd0, 0, 0, 8'hA5, 8'h00, 0, 0, 0);
    loop_en = 1'b0;
    chk("t1_dout", dout, 8'hA5);

    // Modes 1..3, slower SCK, slave answers 0xC3
    for (int m = 1; m < 4; m++) begin
      run_word(1'(m >> 1), 1'(m), 0, 8'd3, 0, 0, 8'h3C, 8'hC3, 0, 0, 0);
      chk("t2_dout", dout, 8'hC3);
    end

    // LSB first
    run_word(0, 0, 1, 8'd0, 0, 0, 8'h01, 8'h80, 0, 0, 0);
    chk("t3_first_sdo", first_sdo, 1);
    chk("t3_dout", dout, 8'h01);

    // Chip select hold across four words on line 1
    cs_watch = 1'b1;
    for (int w = 0; w < 3; w++) begin
      run_word(0, 0, 0, 8'd1, 1, 1, 8'($urandom), 8'($urandom), 0, 0, 0);
      chk("t4_cs_held", cs_n, 2'b01);
    end
    run_word(0, 0, 0, 8'd1, 1, 0, 8'($urandom), 8'($urandom), 0, 0, 0);
    cs_watch = 1'b0;
    chk("t4_cs_released", cs_n, 2'b11);
    chk("t4_cs_continuous", cs_viol, 0);

    // Held select switched to the other line
    run_word(0, 0, 0, 8'd0, 1, 1, 8'h11, 8'h22, 0, 0, 0);
    run_word(0, 0, 0, 8'd0, 0, 0, 8'h33, 8'h44, 0, 0, 0);
    chk("t4b_cs_switch", first_cs, 2'b10);
    chk("t4b_cs_released", cs_n, 2'b11);

    // DMA priority, CPU request while busy dropped
    run_word(1, 1, 0, 8'd0, 0, 0, 8'h5A, 8'h96, 0, 1, 1);
    repeat (4) @(negedge clk);
    chk("t5_no_queue", busy, 0);

    // Reset in the middle of SHIFT
    @(negedge clk);
    cfg_cpol = 1; cfg_cpha = 0; cfg_lsb = 0; cfg_div = 0; cfg_cs_sel = 0; cfg_cs_hold = 0;
    cpu_din = 8'hF0; cpu_req = 1'b1;
    @(negedge clk);
    cpu_req = 1'b0;
    repeat (6) @(negedge clk);
    chk("t6_mid_word", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_cs_n", cs_n, 2'b11);
    chk("t6_sck", sck, 0);
    chk("t6_busy", busy, 0);
    chk("t6_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("t6_no_done", ndone, 0);
    run_word(0, 1, 0, 8'd2, 1, 0, 8'hE7, 8'h5B, 1, 0, 0);

    // Randomized words
    for (int r = 0; r < 10; r++) begin
      run_word(1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom_range(0, 3)),
               1'($urandom), 0, 8'($urandom), 8'($urandom), 1'($urandom),
               1'($urandom), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
